// File: rtl/xintf_pkg.sv
// Shared encodings and defaults for the UART<->XINTF frame sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xintf_pkg;

  localparam int FRAME_LEN_DEF = 16;
  localparam int IDLE_TO_DEF   = 50000;

  // T_BUSY cycles spent waiting for a tx_busy that never shows up
  localparam int TX_NOBUSY_WAIT = 3;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_FILL = 2'd1,
    R_REQ  = 2'd2
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE = 3'd0,
    T_RD   = 3'd1,
    T_LAT  = 3'd2,
    T_SEND = 3'd3,
    T_BUSY = 3'd4
  } tx_state_t;

endpackage

// File: rtl/fifo2_uart_drain.sv
// Drains FIFO2 into the UART transmitter one byte per TX handshake.
// Latency: FIFO2 non-empty at n -> f2_rd_en at n+1, tx_start at n+3.
// Backpressure: no read while tx_busy is high; a missing busy ends the handshake after 4 cycles.
module fifo2_uart_drain
  import xintf_pkg::*;
(
  input  logic       clk50M,
  input  logic       rst,
  input  logic       f2_buf_empty,
  input  logic [7:0] f2_buf_out,
  input  logic       tx_busy,
  output logic       f2_rd_en,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  tx_state_t  state, state_nxt;
  logic       busy_seen;
  logic [1:0] wait_cnt;

  // State register
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) state <= T_IDLE;
    else     state <= state_nxt;
  end

  // Next state and one-cycle strobes decoded from the current state
  always_comb begin
    state_nxt = state;
    f2_rd_en  = 1'b0;
    tx_start  = 1'b0;
    case (state)
      T_IDLE: if (!f2_buf_empty && !tx_busy) state_nxt = T_RD;
      T_RD: begin
        f2_rd_en  = 1'b1;
        state_nxt = T_LAT;
      end
      T_LAT: state_nxt = T_SEND;
      T_SEND: begin
        tx_start  = 1'b1;
        state_nxt = T_BUSY;
      end
      T_BUSY: begin
        if (tx_busy)                                 state_nxt = T_BUSY;
        else if (busy_seen)                          state_nxt = T_IDLE;
        else if (wait_cnt == 2'(TX_NOBUSY_WAIT - 1)) state_nxt = T_IDLE;
      end
      default: state_nxt = T_IDLE;
    endcase
  end

  // Byte capture (held until the next read) and busy handshake tracking
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      tx_data   <= 8'd0;
      busy_seen <= 1'b0;
      wait_cnt  <= 2'd0;
    end else begin
      if (state == T_LAT) tx_data <= f2_buf_out;
      if (state == T_SEND) begin
        busy_seen <= 1'b0;
        wait_cnt  <= 2'd0;
      end else if (state == T_BUSY) begin
        if (tx_busy) busy_seen <= 1'b1;
        else         wait_cnt  <= wait_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/xintf_frame_ctrl.sv
// Packs UART RX bytes into FIFO1 and requests a DSP read per full or idle-closed frame; drains FIFO2 to UART TX.
// Latency: rx_valid at n -> f1_wr_en at n+1; last frame byte at n -> c_xrd_req at n+1; idle close at n+IDLE_TO.
// Backpressure: bytes arriving while FIFO1 is full are dropped and flagged in sticky ovf_err.
module xintf_frame_ctrl
  import xintf_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int IDLE_TO   = IDLE_TO_DEF
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       f1_wr_en,
  output logic [7:0] f1_buf_in,
  input  logic       f1_buf_full,
  input  logic       f1_buf_empty,
  output logic       c_xrd_req,
  output logic       f2_rd_en,
  input  logic [7:0] f2_buf_out,
  input  logic       f2_buf_empty,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       ovf_err
);

  localparam int            IW         = $clog2(IDLE_TO + 1);
  localparam logic [7:0]    FL8        = 8'(FRAME_LEN);
  // idle_cnt value one cycle before the close, so the request lands exactly IDLE_TO after the last byte
  localparam logic [IW-1:0] IDLE_CLOSE = IW'(IDLE_TO - 2);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TO);

  rx_state_t     rx_state, rx_nxt;
  logic [7:0]    byte_cnt;
  logic [IW-1:0] idle_cnt;
  logic          empty_seen;
  logic          accept;
  logic          frame_hit;
  logic          idle_hit;
  logic          drained;

  assign accept    = rx_valid & ~f1_buf_full;
  assign frame_hit = accept && (byte_cnt + 8'd1 == FL8);
  assign idle_hit  = !rx_valid && (idle_cnt == IDLE_CLOSE);
  assign drained   = f1_buf_empty & empty_seen;
  assign c_xrd_req = (rx_state == R_REQ);

  // RX state register
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) rx_state <= R_IDLE;
    else     rx_state <= rx_nxt;
  end

  // RX next state: a one-byte frame goes straight from idle to request
  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      R_IDLE:  if (accept) rx_nxt = frame_hit ? R_REQ : R_FILL;
      R_FILL:  if (frame_hit || idle_hit) rx_nxt = R_REQ;
      R_REQ:   if (drained) rx_nxt = R_IDLE;
      default: rx_nxt = R_IDLE;
    endcase
  end

  // Frame byte count, RX silence count and FIFO1 empty history
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      byte_cnt   <= 8'd0;
      idle_cnt   <= '0;
      empty_seen <= 1'b0;
    end else begin
      empty_seen <= (rx_state == R_REQ) && f1_buf_empty;
      case (rx_state)
        R_IDLE: begin
          idle_cnt <= '0;
          if (accept) byte_cnt <= 8'd1;
        end
        R_FILL: begin
          if (rx_valid)                   idle_cnt <= '0;
          else if (idle_cnt != IDLE_MAX)  idle_cnt <= idle_cnt + 1'b1;
          if (accept && byte_cnt != FL8)  byte_cnt <= byte_cnt + 8'd1;
        end
        R_REQ: begin
          idle_cnt <= '0;
          if (drained) byte_cnt <= 8'd0;
        end
        default: begin
          idle_cnt <= '0;
          byte_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Registered FIFO1 write port and sticky overflow flag
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      f1_wr_en  <= 1'b0;
      f1_buf_in <= 8'd0;
      ovf_err   <= 1'b0;
    end else begin
      f1_wr_en <= accept;
      if (accept)                  f1_buf_in <= rx_data;
      if (rx_valid && f1_buf_full) ovf_err   <= 1'b1;
    end
  end

  fifo2_uart_drain u_drain (
    .clk50M       (clk50M),
    .rst          (rst),
    .f2_buf_empty (f2_buf_empty),
    .f2_buf_out   (f2_buf_out),
    .tx_busy      (tx_busy),
    .f2_rd_en     (f2_rd_en),
    .tx_start     (tx_start),
    .tx_data      (tx_data)
  );

endmodule

// File: tb/tb_xintf_frame_ctrl.sv
// Bench for xintf_frame_ctrl: directed RX frames and FIFO2 drains against a frame/queue model.
// Latency: n/a.
// Backpressure: FIFO1 full and UART busy driven by the bench.
module tb_xintf_frame_ctrl;

  localparam int FL  = 16;
  localparam int ITO = 100;

  logic       clk50M;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       f1_wr_en;
  logic [7:0] f1_buf_in;
  logic       f1_buf_full;
  logic       f1_buf_empty;
  logic       c_xrd_req;
  logic       f2_rd_en;
  logic [7:0] f2_buf_out;
  logic       f2_buf_empty;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       ovf_err;

  xintf_frame_ctrl #(.FRAME_LEN(FL), .IDLE_TO(ITO)) dut (
    .clk50M(clk50M), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .f1_wr_en(f1_wr_en), .f1_buf_in(f1_buf_in), .f1_buf_full(f1_buf_full),
    .f1_buf_empty(f1_buf_empty), .c_xrd_req(c_xrd_req), .f2_rd_en(f2_rd_en),
    .f2_buf_out(f2_buf_out), .f2_buf_empty(f2_buf_empty), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .ovf_err(ovf_err)
  );

  initial begin
    clk50M = 1'b0;
    forever #5 clk50M = ~clk50M;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // FIFO2 contents and UART busy model
  logic [7:0] f2_mem [0:15];
  int f2_cnt = 0;
  int f2_ptr = 0;
  int busy_len = 20;
  int busy_cnt;
  logic rd_pend;

  initial begin
    f2_buf_out   = 8'd0;
    f2_buf_empty = 1'b1;
    tx_busy      = 1'b0;
    busy_cnt     = 0;
    rd_pend      = 1'b0;
    forever begin
      @(negedge clk50M);
      if (rd_pend) begin
        f2_buf_out = f2_mem[f2_ptr];
        f2_ptr++;
      end
      rd_pend = f2_rd_en;
      if (tx_start) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy      = (busy_cnt > 0);
      f2_buf_empty = (f2_ptr == f2_cnt);
    end
  end

  // Reference model and per-cycle comparison
  int cyc = 0;
  int acc = 0, since = 0;
  logic req_m = 1'b0, pe = 1'b0, ovf_m = 1'b0, req_prev = 1'b0, holding = 1'b0;
  logic [7:0] held = 8'd0;
  int wr_cnt = 0, start_cnt = 0, sent_idx = 0;
  int last_rx_cyc = 0, rise_cyc = 0, rd_cyc = 0, last_start = 0, last_spacing = 0;

  initial begin
    forever begin
      @(posedge clk50M);
      #1;
      cyc++;
      if (rst) begin
        acc = 0; since = 0; req_m = 0; pe = 0; ovf_m = 0; holding = 0; req_prev = 0;
      end else begin
        check("f1_wr_en", f1_wr_en, rx_valid & ~f1_buf_full);
        if (rx_valid && !f1_buf_full) check("f1_buf_in", f1_buf_in, rx_data);
        if (f1_wr_en) wr_cnt++;
        if (rx_valid && f1_buf_full) ovf_m = 1'b1;
        check("ovf_err", ovf_err, ovf_m);

        if (req_m) begin
          if (f1_buf_empty && pe) begin
            req_m = 0; acc = 0; since = 0; pe = 0;
          end else pe = f1_buf_empty;
        end else begin
          if (rx_valid && !f1_buf_full) acc++;
          if (rx_valid) since = 0;
          else if (acc > 0) since++;
          if (acc == FL || (acc > 0 && since == ITO - 1)) begin
            req_m = 1; pe = 0;
          end
        end
        check("c_xrd_req", c_xrd_req, req_m);
        if (c_xrd_req && !req_prev) rise_cyc = cyc + 1;
        req_prev = c_xrd_req;
        if (rx_valid) last_rx_cyc = cyc;

        if (f2_rd_en) begin
          check("rd_while_busy", tx_busy, 1'b0);
          rd_cyc = cyc + 1;
        end
        if (tx_start) begin
          check("tx_data", tx_data, f2_mem[sent_idx]);
          check("rd_to_start", cyc + 1 - rd_cyc, 2);
          held = f2_mem[sent_idx];
          sent_idx++;
          start_cnt++;
          last_spacing = cyc + 1 - last_start;
          last_start   = cyc + 1;
          holding = 1;
        end else if (holding && tx_busy) begin
          check("tx_data_hold", tx_data, held);
        end else if (!tx_busy) holding = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic full, input int gap);
    rx_valid = 1'b1; rx_data = d; f1_buf_full = full;
    tick(1);
    rx_valid = 1'b0; f1_buf_full = 1'b0;
    tick(gap - 1);
  endtask

  task automatic drain();
    f1_buf_empty = 1'b1;
    tick(2);
    f1_buf_empty = 1'b0;
    tick(2);
  endtask

  task automatic preload(input logic [7:0] d);
    f2_mem[f2_cnt] = d;
    f2_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_f1_wr_en"},  f1_wr_en,  0);
    check({tag, "_f1_buf_in"}, f1_buf_in, 0);
    check({tag, "_c_xrd_req"}, c_xrd_req, 0);
    check({tag, "_f2_rd_en"},  f2_rd_en,  0);
    check({tag, "_tx_start"},  tx_start,  0);
    check({tag, "_tx_data"},   tx_data,   0);
    check({tag, "_ovf_err"},   ovf_err,   0);
  endtask

  initial begin
    int w0, k;
    rst = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; f1_buf_full = 1'b0; f1_buf_empty = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    tick(3);
    rst = 1'b0;
    tick(2);

    // Full 16-byte frame, 40-cycle spacing
    w0 = wr_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i), 1'b0, 40);
    check("t1_writes", wr_cnt - w0, 16);
    check("t1_req_delay", rise_cyc - last_rx_cyc, 1);
    check("t1_req_high", c_xrd_req, 1);
    drain();
    check("t1_req_low", c_xrd_req, 0);

    // Idle-closed partial frame
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'hB0 + 8'(i), 1'b0, 5);
    tick(110);
    check("t2_writes", wr_cnt - w0, 3);
    check("t2_idle_delay", rise_cyc - last_rx_cyc, 100);
    drain();
    check("t2_byte_cnt", dut.byte_cnt, 0);

    // FIFO1 full during bytes 2 and 4
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), (i == 1 || i == 3), 5);
    check("t3_writes", wr_cnt - w0, 3);
    check("t3_ovf", ovf_err, 1);
    tick(110);
    drain();

    // FIFO2 drain, 20-cycle busy
    busy_len = 20;
    for (int i = 0; i < 8; i++) preload(8'hA0 + 8'(i));
    k = 0;
    while (start_cnt < 8 && k < 2000) begin tick(1); k++; end
    check("t4_starts", start_cnt, 8);
    tick(30);
    check("t4_ovf_sticky", ovf_err, 1);

    // UART never asserts busy
    busy_len = 0;
    for (int i = 0; i < 3; i++) preload(8'h51 + 8'(i));
    k = 0;
    while (start_cnt < 11 && k < 200) begin tick(1); k++; end
    check("t5_starts", start_cnt, 11);
    check("t5_spacing", last_spacing, 7);
    tick(5);

    // Reset while requesting and transmitting
    busy_len = 60;
    preload(8'h66);
    k = 0;
    while (start_cnt < 12 && k < 50) begin tick(1); k++; end
    check("t6_start", start_cnt, 12);
    for (int i = 0; i < 16; i++) send_byte(8'hD0 + 8'(i), 1'b0, 2);
    check("t6_req_before_rst", c_xrd_req, 1);
    rst = 1'b1;
    #1 check_all_zero("t6_rst");
    tick(3);
    rst = 1'b0;
    tick(80);
    check("t6_no_resend", start_cnt, 12);
    w0 = wr_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'hE0 + 8'(i), 1'b0, 3);
    check("t6_writes", wr_cnt - w0, 16);
    check("t6_req_delay", rise_cyc - last_rx_cyc, 1);
    drain();
    check("t6_req_low", c_xrd_req, 0);
    check("t6_ovf_clear", ovf_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xintf_frame_ctrl.md
# xintf_frame_ctrl

Frame sequencer for the UART↔XINTF bridge.
- Packs UART RX bytes into FIFO1 of xintf_top and raises c_xrd_req once a full frame, or an idle-terminated partial frame, is buffered for the DSP.
- Independently drains FIFO2 (bytes written by the DSP over XINTF) into the UART transmitter, one byte per TX handshake.
- Sits between the UART RX/TX cores and the FIFO interface of xintf_top.

## Interface
Parameters:
- FRAME_LEN, 16: bytes per frame. Range 1..255.
- IDLE_TO, 50000: clk50M cycles of RX silence that close a partial frame (1 ms). Must be ≥2.

Ports:
- clk50M  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- f1_wr_en  out  1  FIFO1 write strobe
- f1_buf_in  out  8  FIFO1 write data
- f1_buf_full  in  1  FIFO1 full
- f1_buf_empty  in  1  FIFO1 empty
- c_xrd_req  out  1  frame-ready request to DSP, high active
- f2_rd_en  out  1  FIFO2 read strobe
- f2_buf_out  in  8  FIFO2 read data, valid 1 cycle after f2_rd_en
- f2_buf_empty  in  1  FIFO2 empty
- tx_start  out  1  one-cycle strobe to UART TX
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls
- tx_busy  in  1  UART TX busy
- ovf_err  out  1  sticky: RX byte dropped because FIFO1 was full

## Operation
RX FSM: R_IDLE, R_FILL, R_REQ.
- R_IDLE: rx_valid → write byte, byte_cnt=1, go to R_FILL. Exception: if FRAME_LEN==1, go directly to R_REQ.
- R_FILL:
  - Each rx_valid writes a byte, increments byte_cnt and clears idle_cnt.
  - Otherwise idle_cnt increments.
  - byte_cnt reaches FRAME_LEN → R_REQ.
  - idle_cnt reaches IDLE_TO-1 → R_REQ.
- R_REQ:
  - c_xrd_req=1.
  - rx_valid bytes are still written and belong to the current drain.
  - f1_buf_empty high on 2 consecutive cycles → R_IDLE, byte_cnt=0, idle_cnt=0.
- Write rule, all states: f1_wr_en=rx_valid & ~f1_buf_full, f1_buf_in=rx_data in the same cycle (combinational pass of a registered strobe is not allowed; both outputs are registered, 1-cycle latency).
- rx_valid while f1_buf_full: byte dropped, ovf_err set, byte_cnt not incremented. ovf_err is cleared only by rst.

TX FSM: T_IDLE, T_RD, T_LAT, T_SEND, T_BUSY.
- T_IDLE: ~f2_buf_empty & ~tx_busy → T_RD.
- T_RD: f2_rd_en=1 for one cycle → T_LAT.
- T_LAT: capture f2_buf_out into tx_data → T_SEND.
- T_SEND: tx_start=1 for one cycle → T_BUSY.
- T_BUSY: tx_busy seen high, then low → T_IDLE. If tx_busy is not seen high within 4 cycles, treat the transmission as complete → T_IDLE.

The two FSMs are fully independent; simultaneous RX write and FIFO2 read in the same cycle is legal.

## Timing
- Reset values: f1_wr_en=0, f1_buf_in=0, c_xrd_req=0, f2_rd_en=0, tx_start=0, tx_data=0, ovf_err=0. Both FSMs go to their IDLE state and all counters clear.
- rx_valid at cycle n → f1_wr_en high at n+1.
- Final frame byte at cycle n → c_xrd_req high at n+1.
- Idle close: last byte at cycle n → c_xrd_req high at n+IDLE_TO.
- c_xrd_req falls 1 cycle after the second consecutive empty sample.
- FIFO2 non-empty at cycle n (TX idle) → f2_rd_en at n+1, tx_start at n+3. Minimum spacing between tx_start pulses is 5 cycles plus the tx_busy duration.
- rst asserted mid-frame or mid-transmit aborts immediately: pulses are truncated, the request drops and nothing is re-sent. FIFO contents are not touched by this block.
- byte_cnt is 8 bits and saturates at FRAME_LEN; idle_cnt width is $clog2(IDLE_TO+1) and never wraps.

## Structure
- Shared package xintf_pkg holds the RX/TX state encodings and the default FRAME_LEN/IDLE_TO constants.
- The TX drain FSM is one natural sub-module, fifo2_uart_drain. The RX/frame logic stays in the top.

## Test plan
- 16 rx_valid bytes 0xA0..0xAF, 40-cycle spacing → 16 f1_wr_en with matching data. c_xrd_req rises 1 cycle after byte 0xAF and falls after the bench drives f1_buf_empty high for 2 cycles.
- 3 bytes 0xB0..0xB2 then silence, IDLE_TO=100 → c_xrd_req rises exactly 100 cycles after 0xB2. byte_cnt is 0 after the drain.
- f1_buf_full held high during 2 of 5 bytes → 3 writes, ovf_err=1 and stays 1 until rst.
- FIFO2 model preloaded with 0x00A0..0x00A7 (low bytes); tx_busy model 20 cycles per byte → 8 tx_start pulses carrying tx_data 0xA0..0xA7, and no f2_rd_en while tx_busy is high.
- tx_busy never asserted → TX FSM returns to T_IDLE 4 cycles after tx_start, and the next byte follows.
- rst pulsed while c_xrd_req=1 and in T_BUSY → all outputs at their reset values within the same cycle. The next frame after release behaves normally.
